wb_align_queue: RTL and testbench

WB_ALIGN_QUEUE -- requirements
Module: wb_align_queue

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_align_queue_if.sv | 32 +++
 rtl/load_align.sv | 39 +++
 rtl/wb_align_queue.sv | 69 ++++++
 tb/tb_wb_align_queue.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the writeback align queue
package wb_pkg;
  typedef enum logic [3:0] {
    alu_out, br_en, u_imm, pc_plus4, lb, lbu, lh, lhu, lw, lwu, ld
  } regfilemux_sel_t;
  typedef struct packed {
    logic [4:0] rd;
    regfilemux_sel_t sel;
    logic br_en;
    logic [2:0] addr_lo;
    logic [63:0] alu_out;
    logic [63:0] u_imm;
    logic [63:0] pc;
    logic [63:0] mdr;
  } wb_entry_t;
endpackage

// File: rtl/wb_align_queue_if.sv
// wb_align_queue_if: MEM-stage push port and regfile commit port
interface wb_align_queue_if #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4
);
  import wb_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [4:0] in_rd;
  regfilemux_sel_t in_sel;
  logic [XLEN-1:0] in_alu_out;
  logic [XLEN-1:0] in_u_imm;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_mdr;
  logic in_br_en;
  logic [$clog2(XLEN/8)-1:0] in_addr_lo;
  logic flush;
  logic wr_block;
  logic [4:0] rd_wb;
  logic load_regfile_wb;
  logic [XLEN-1:0] regfilemux_out_wb;
  logic wb_err;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output in_valid, in_rd, in_sel, in_alu_out, in_u_imm, in_pc, in_mdr, in_br_en, in_addr_lo, flush, wr_block,
    input in_ready, rd_wb, load_regfile_wb, regfilemux_out_wb, wb_err, count
  );
  modport slave (
    input in_valid, in_rd, in_sel, in_alu_out, in_u_imm, in_pc, in_mdr, in_br_en, in_addr_lo, flush, wr_block,
    output in_ready, rd_wb, load_regfile_wb, regfilemux_out_wb, wb_err, count
  );
endinterface

// File: rtl/load_align.sv
// load_align: picks the writeback source, aligns/extends loads, flags bad loads
module load_align import wb_pkg::*; #(
  parameter int XLEN = 32
) (
  input wb_entry_t e_i,
  output logic [XLEN-1:0] data_o,
  output logic err_o
);
  localparam int AW = $clog2(XLEN/8);
  logic [AW-1:0] a;
  logic [XLEN-1:0] m;
  logic [7:0] sb;
  logic [15:0] sh;
  logic [31:0] sw;
  assign a = e_i.addr_lo[AW-1:0];
  assign m = e_i.mdr[XLEN-1:0];
  assign sb = 8'(m >> {a, 3'b000});
  assign sh = 16'(m >> {a & ~AW'(1), 3'b000});
  assign sw = 32'(m >> {a & ~AW'(3), 3'b000});
  // source select with sign/zero extension; lwu and ld do not exist on a 32-bit datapath
  always_comb begin
    data_o = '0;
    err_o = 1'b0;
    case (e_i.sel)
      alu_out: data_o = e_i.alu_out[XLEN-1:0];
      br_en: data_o = XLEN'(e_i.br_en);
      u_imm: data_o = e_i.u_imm[XLEN-1:0];
      pc_plus4: data_o = e_i.pc[XLEN-1:0] + XLEN'(4);
      lb: data_o = XLEN'($signed(sb));
      lbu: data_o = XLEN'(sb);
      lh: begin data_o = XLEN'($signed(sh)); err_o = a[0]; end
      lhu: begin data_o = XLEN'(sh); err_o = a[0]; end
      lw: begin data_o = XLEN'($signed(sw)); err_o = |a[1:0]; end
      lwu: begin data_o = XLEN'(sw); err_o = (|a[1:0]) || (XLEN == 32); end
      ld: begin data_o = m; err_o = (|a) || (XLEN == 32); end
      default: ;
    endcase
  end
endmodule

// File: rtl/wb_align_queue.sv
// wb_align_queue: small FIFO of completing instructions that aligns and commits one per cycle
module wb_align_queue import wb_pkg::*; #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  wb_align_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  if (!(XLEN == 32 || XLEN == 64) || DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("wb_align_queue: XLEN must be 32/64 and DEPTH a power of 2 in 2..8");
  end
  wb_entry_t mem_q [DEPTH];
  wb_entry_t in_e, head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0] rd_wb_q, rd_wb_d;
  logic [XLEN-1:0] data_q, data_d, res;
  logic load_q, load_d, err_q, err_d, res_err, rdy, push, pop;
  assign in_e = '{rd: bus.in_rd, sel: bus.in_sel, br_en: bus.in_br_en, addr_lo: 3'(bus.in_addr_lo),
                  alu_out: 64'(bus.in_alu_out), u_imm: 64'(bus.in_u_imm), pc: 64'(bus.in_pc), mdr: 64'(bus.in_mdr)};
  assign head = mem_q[rd_ptr_q];
  load_align #(.XLEN(XLEN)) u_align (.e_i(head), .data_o(res), .err_o(res_err));
  assign rdy = count_q < CW'(DEPTH);
  assign push = bus.in_valid & rdy & ~bus.flush;
  assign pop = (count_q != '0) & ~bus.wr_block & ~bus.flush;
  assign bus.in_ready = rdy;
  assign bus.count = count_q;
  assign bus.rd_wb = rd_wb_q;
  assign bus.regfilemux_out_wb = data_q;
  assign bus.load_regfile_wb = load_q;
  assign bus.wb_err = err_q;
  // flush empties the queue and cancels both strobes; writes to x0 are silently consumed
  always_comb begin
    count_d = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
    wr_ptr_d = bus.flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = bus.flush ? '0 : rd_ptr_q + PW'(pop);
    rd_wb_d = pop ? head.rd : rd_wb_q;
    data_d = pop ? res : data_q;
    load_d = pop & ~res_err & (head.rd != 5'd0);
    err_d = pop & res_err & (head.rd != 5'd0);
  end
  // occupancy, pointers and commit registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_wb_q <= '0;
      data_q <= '0;
      load_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_wb_q <= rd_wb_d;
      data_q <= data_d;
      load_q <= load_d;
      err_q <= err_d;
    end
  end
  // entry storage holds raw fields and is only meaningful below count, so it is not reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_e;
  end
endmodule

// File: tb/tb_wb_align_queue.sv
// tb_wb_align_queue: drives 32- and 64-bit queues in lockstep against a queue-based reference
module tb_wb_align_queue;
  import wb_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic s_valid, s_br, s_flush, s_block;
  logic [4:0] s_rd;
  regfilemux_sel_t s_sel;
  logic [63:0] s_alu, s_uimm, s_pc, s_mdr;
  logic [2:0] s_addr;
  int vecs = 0;
  int errs = 0;
  wb_entry_t mq [2][$];
  logic [63:0] e_data [2];
  logic [4:0] e_rd [2];
  bit e_load [2];
  bit e_err [2];
  wb_align_queue_if #(.XLEN(32), .DEPTH(DEPTH)) b32 ();
  wb_align_queue_if #(.XLEN(64), .DEPTH(DEPTH)) b64 ();
  assign b32.in_valid = s_valid;
  assign b32.in_rd = s_rd;
  assign b32.in_sel = s_sel;
  assign b32.in_alu_out = s_alu[31:0];
  assign b32.in_u_imm = s_uimm[31:0];
  assign b32.in_pc = s_pc[31:0];
  assign b32.in_mdr = s_mdr[31:0];
  assign b32.in_br_en = s_br;
  assign b32.in_addr_lo = s_addr[1:0];
  assign b32.flush = s_flush;
  assign b32.wr_block = s_block;
  assign b64.in_valid = s_valid;
  assign b64.in_rd = s_rd;
  assign b64.in_sel = s_sel;
  assign b64.in_alu_out = s_alu;
  assign b64.in_u_imm = s_uimm;
  assign b64.in_pc = s_pc;
  assign b64.in_mdr = s_mdr;
  assign b64.in_br_en = s_br;
  assign b64.in_addr_lo = s_addr;
  assign b64.flush = s_flush;
  assign b64.wr_block = s_block;
  wb_align_queue #(.XLEN(32), .DEPTH(DEPTH)) u32 (.clk(clk), .rst(rst), .bus(b32));
  wb_align_queue #(.XLEN(64), .DEPTH(DEPTH)) u64 (.clk(clk), .rst(rst), .bus(b64));

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wb_entry_t mk(int xl);
    logic [63:0] mask = (xl == 64) ? '1 : 64'hFFFF_FFFF;
    return '{rd: s_rd, sel: s_sel, br_en: s_br, addr_lo: (xl == 64) ? s_addr : {1'b0, s_addr[1:0]},
             alu_out: s_alu & mask, u_imm: s_uimm & mask, pc: s_pc & mask, mdr: s_mdr & mask};
  endfunction

  function automatic void ref_result(int xl, wb_entry_t e, output logic [63:0] d, output bit er);
    logic [63:0] mask = (xl == 64) ? '1 : 64'hFFFF_FFFF;
    logic [63:0] v;
    int sz = 0;
    bit sgn = 0;
    d = '0;
    case (e.sel)
      alu_out: d = e.alu_out;
      br_en: d = 64'(e.br_en);
      u_imm: d = e.u_imm;
      pc_plus4: d = (e.pc + 64'd4) & mask;
      lb: begin sz = 1; sgn = 1; end
      lbu: sz = 1;
      lh: begin sz = 2; sgn = 1; end
      lhu: sz = 2;
      lw: begin sz = 4; sgn = 1; end
      lwu: sz = 4;
      ld: sz = 8;
      default: ;
    endcase
    if (sz != 0) begin
      v = e.mdr >> (8 * e.addr_lo);
      if (sz < 8) v = v % (64'd1 << (8 * sz));
      if (sgn && sz < 8 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
      d = v & mask;
    end
    er = (sz != 0 && (e.addr_lo % sz) != 0) || (xl == 32 && (e.sel == lwu || e.sel == ld));
  endfunction

  task automatic check_all();
    chk("count32", 64'(b32.count), 64'(mq[0].size()));
    chk("ready32", 64'(b32.in_ready), 64'(mq[0].size() < DEPTH));
    chk("load32", 64'(b32.load_regfile_wb), 64'(e_load[0]));
    chk("err32", 64'(b32.wb_err), 64'(e_err[0]));
    if (e_load[0]) begin
      chk("rd32", 64'(b32.rd_wb), 64'(e_rd[0]));
      chk("data32", 64'(b32.regfilemux_out_wb), e_data[0]);
    end
    chk("count64", 64'(b64.count), 64'(mq[1].size()));
    chk("ready64", 64'(b64.in_ready), 64'(mq[1].size() < DEPTH));
    chk("load64", 64'(b64.load_regfile_wb), 64'(e_load[1]));
    chk("err64", 64'(b64.wb_err), 64'(e_err[1]));
    if (e_load[1]) begin
      chk("rd64", 64'(b64.rd_wb), 64'(e_rd[1]));
      chk("data64", b64.regfilemux_out_wb, e_data[1]);
    end
  endtask

  task automatic tick();
    bit pu [2];
    bit po [2];
    wb_entry_t e;
    logic [63:0] d;
    bit er;
    for (int k = 0; k < 2; k++) begin
      pu[k] = s_valid && mq[k].size() < DEPTH && !s_flush;
      po[k] = mq[k].size() > 0 && !s_block && !s_flush;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      e_load[k] = 0;
      e_err[k] = 0;
      if (po[k]) begin
        e = mq[k].pop_front();
        ref_result(k ? 64 : 32, e, d, er);
        e_rd[k] = e.rd;
        e_data[k] = d;
        e_load[k] = !er && e.rd != 0;
        e_err[k] = er && e.rd != 0;
      end
      if (s_flush) mq[k].delete();
      else if (pu[k]) mq[k].push_back(mk(k ? 64 : 32));
    end
    #1;
    check_all();
  endtask

  task automatic put(bit v, regfilemux_sel_t sel, logic [4:0] rd, logic [63:0] val, logic [2:0] addr);
    s_valid = v;
    s_sel = sel;
    s_rd = rd;
    s_alu = val;
    s_uimm = val;
    s_pc = val;
    s_mdr = val;
    s_br = val[0];
    s_addr = addr;
  endtask

  task automatic rst_chk();
    chk("rst_count32", 64'(b32.count), 0);
    chk("rst_load32", 64'(b32.load_regfile_wb), 0);
    chk("rst_err32", 64'(b32.wb_err), 0);
    chk("rst_rd32", 64'(b32.rd_wb), 0);
    chk("rst_data32", 64'(b32.regfilemux_out_wb), 0);
    chk("rst_count64", 64'(b64.count), 0);
    chk("rst_load64", 64'(b64.load_regfile_wb), 0);
    chk("rst_err64", 64'(b64.wb_err), 0);
    chk("rst_rd64", 64'(b64.rd_wb), 0);
    chk("rst_data64", b64.regfilemux_out_wb, 0);
  endtask

  initial begin
    s_flush = 0;
    s_block = 0;
    put(0, alu_out, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      e_load[k] = 0;
      e_err[k] = 0;
      e_rd[k] = 0;
      e_data[k] = 0;
    end
    #2 rst_chk();
    @(negedge clk) rst = 0;
    put(1, lb, 5'd5, 64'h80FF_1234, 3'd2);
    tick();
    put(1, lbu, 5'd6, 64'h80FF_1234, 3'd2);
    tick();
    chk("lb_strobe", 64'(b32.load_regfile_wb), 1);
    chk("lb32", 64'(b32.regfilemux_out_wb), 64'hFFFF_FFFF);
    put(0, alu_out, 0, 0, 0);
    tick();
    chk("lbu32", 64'(b32.regfilemux_out_wb), 64'h0000_00FF);
    put(1, lwu, 5'd7, 64'h8000_0001_DEAD_BEEF, 3'd4);
    tick();
    put(1, lw, 5'd8, 64'h8000_0001_DEAD_BEEF, 3'd4);
    tick();
    chk("lwu64", b64.regfilemux_out_wb, 64'h0000_0000_8000_0001);
    put(0, alu_out, 0, 0, 0);
    tick();
    chk("lw64", b64.regfilemux_out_wb, 64'hFFFF_FFFF_8000_0001);
    s_block = 1;
    for (int i = 0; i < 5; i++) begin
      put(1, alu_out, 5'(i + 1), 64'((i + 1) * 17), 0);
      tick();
    end
    chk("full_ready", 64'(b32.in_ready), 0);
    chk("full_count", 64'(b32.count), 4);
    s_block = 0;
    put(0, alu_out, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_strobe", 64'(b32.load_regfile_wb), 1);
      chk("drain_rd", 64'(b32.rd_wb), 64'(i + 1));
    end
    put(1, lh, 5'd9, 64'h1234, 3'd1);
    tick();
    put(1, alu_out, 5'd3, 64'h55, 0);
    tick();
    chk("mis_err", 64'(b32.wb_err), 1);
    chk("mis_nostrobe", 64'(b32.load_regfile_wb), 0);
    put(0, alu_out, 0, 0, 0);
    tick();
    chk("after_mis_rd", 64'(b32.rd_wb), 3);
    chk("after_mis_data", 64'(b32.regfilemux_out_wb), 64'h55);
    s_block = 1;
    for (int i = 0; i < 3; i++) begin
      put(1, alu_out, 5'(i + 11), 64'(i + 100), 0);
      tick();
    end
    s_flush = 1;
    put(1, alu_out, 5'd10, 64'hAA, 0);
    tick();
    chk("flush_count", 64'(b32.count), 0);
    chk("flush_nostrobe", 64'(b32.load_regfile_wb), 0);
    s_flush = 0;
    s_block = 0;
    put(0, alu_out, 0, 0, 0);
    tick();
    chk("flush_not_stored", 64'(b32.count), 0);
    repeat (300) begin
      s_valid = $urandom_range(0, 9) < 7;
      s_sel = regfilemux_sel_t'($urandom_range(0, 10));
      s_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      s_alu = {$urandom, $urandom};
      s_uimm = {$urandom, $urandom};
      s_pc = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      s_mdr = {$urandom, $urandom};
      s_br = 1'($urandom);
      s_addr = 3'($urandom);
      s_block = $urandom_range(0, 3) == 0;
      s_flush = $urandom_range(0, 19) == 0;
      tick();
    end
    s_flush = 0;
    s_block = 1;
    for (int i = 0; i < 3; i++) begin
      put(1, alu_out, 5'(i + 20), 64'(i + 200), 0);
      tick();
    end
    s_block = 0;
    put(0, alu_out, 0, 0, 0);
    tick();
    #2 rst = 1;
    #1 rst_chk();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      e_load[k] = 0;
      e_err[k] = 0;
    end
    @(negedge clk) rst = 0;
    put(1, pc_plus4, 5'd4, 64'hFFFF_FFFC, 0);
    tick();
    put(0, alu_out, 0, 0, 0);
    tick();
    chk("pc4_strobe", 64'(b32.load_regfile_wb), 1);
    chk("pc4_wrap32", 64'(b32.regfilemux_out_wb), 0);
    chk("pc4_64", b64.regfilemux_out_wb, 64'h1_0000_0000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
